// File: rtl/wb_prog_loader.sv
// wb_prog_loader: Wishbone classic slave that streams program words into the
// osiris_i instruction memory and holds the core in reset until firmware sets
// the run bit.
// Optional build macro: WB_PROG_LOADER_CHECKSUM_EN adds a read-only running
// checksum register at offset 0x10; without it that offset is unmapped.
module wb_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MEM_AW    = 10,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              core_rst_n_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_WR = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Word offsets within the 256-byte window.
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_PTR    = 6'h02;
    localparam logic [5:0] OFF_DATA   = 6'h03;
`ifdef WB_PROG_LOADER_CHECKSUM_EN
    localparam logic [5:0] OFF_CSUM   = 6'h04;
`endif

    state_t            state_q;
    logic [MEM_AW-1:0] ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              run_q;
    logic              err_q;
    logic              wrap_q;
`ifdef WB_PROG_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q;
`endif

    logic              req;
    logic [5:0]        off;
    logic [31:0]       rdata_d;
    logic [CNT_W-1:0]  count_d;
    logic              unused_adr;

    // Byte-lane bits of the address carry no information for word registers.
    assign unused_adr = ^wb_adr_i[1:0];

    // Request decode: only cycles aimed at our 256-byte window are seen.
    always_comb begin
        req = wb_cyc_i && wb_stb_i && (wb_adr_i[31:8] == BASE_ADDR[31:8]);
        off = wb_adr_i[7:2];
    end

    // Read mux and saturating increment of the loaded-word counter.
    always_comb begin
        rdata_d = '0;
        case (off)
            OFF_CTRL:   rdata_d = {31'b0, run_q};
            OFF_STATUS: rdata_d = {16'(count_q), 13'b0, wrap_q, err_q, run_q};
            OFF_PTR:    rdata_d = 32'({ptr_q, 2'b00});
`ifdef WB_PROG_LOADER_CHECKSUM_EN
            OFF_CSUM:   rdata_d = csum_q;
`endif
            default:    rdata_d = '0;
        endcase
        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    end

    // Bus FSM with registered outputs; also owns all loader state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= '0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            core_rst_n_o <= 1'b0;
            ptr_q        <= '0;
            count_q      <= '0;
            run_q        <= 1'b0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
`ifdef WB_PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            // The core follows run with one register of delay.
            core_rst_n_o <= run_q;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (wb_we_i && (off == OFF_DATA) && !run_q) begin
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= ptr_q;
                            mem_wdata_o <= wb_dat_i;
                            state_q     <= MEM_WR;
                        end else begin
                            wb_ack_o <= 1'b1;
                            state_q  <= ACK;
                            if (!wb_we_i) begin
                                wb_dat_o <= rdata_d;
                            end else begin
                                case (off)
                                    OFF_CTRL: begin
                                        // Clear and run may land together.
                                        run_q <= wb_dat_i[0];
                                        if (wb_dat_i[1]) begin
                                            count_q <= '0;
                                            err_q   <= 1'b0;
                                            wrap_q  <= 1'b0;
`ifdef WB_PROG_LOADER_CHECKSUM_EN
                                            csum_q  <= '0;
`endif
                                        end
                                    end
                                    OFF_PTR:  ptr_q <= wb_dat_i[MEM_AW+1:2];
                                    // Only reachable while the core runs.
                                    OFF_DATA: err_q <= 1'b1;
                                    default:  ;
                                endcase
                            end
                        end
                    end
                end
                MEM_WR: begin
                    // Hold the write request stable until the memory takes it.
                    if (mem_ready_i) begin
                        mem_we_o <= 1'b0;
                        ptr_q    <= ptr_q + MEM_AW'(1);
                        count_q  <= count_d;
                        if (ptr_q == '1) begin
                            wrap_q <= 1'b1;
                        end
`ifdef WB_PROG_LOADER_CHECKSUM_EN
                        csum_q   <= csum_q + mem_wdata_o;
`endif
                        wb_ack_o <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    wb_ack_o <= 1'b0;
                    wb_dat_o <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_prog_loader.sv
// tb_wb_prog_loader: randomized self-checking bench for wb_prog_loader with a
// register-level reference model of the loader.
module tb_wb_prog_loader;

    localparam int          MEM_AW = 10;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_PTR  = BASE + 32'h08;
    localparam logic [31:0] A_DATA = BASE + 32'h0C;
    localparam logic [31:0] A_CSUM = BASE + 32'h10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0]       wb_adr_i, wb_dat_i, wb_dat_o;
    logic              wb_ack_o;
    logic              mem_we_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ready_i;
    logic              core_rst_n_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_ptr, m_count;
    bit          m_run, m_err, m_wrap;
    logic [31:0] m_csum;

    // Results of the most recent bus transfer
    logic [31:0]       x_rdata, x_post_dat, x_wdata, x_exp_rd;
    int                x_cycles, x_we_cycles;
    logic [MEM_AW-1:0] x_waddr, x_exp_addr;
    bit                x_bad, x_exp_mem, x_done;
    logic              x_core_ack, x_post_ack;

    always #5 clk = ~clk;

    wb_prog_loader #(.BASE_ADDR(BASE), .MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .core_rst_n_o(core_rst_n_o)
    );

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_run = 0; m_err = 0; m_wrap = 0; m_csum = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        logic [7:0]  o;
        logic [31:0] v;
        o = adr[7:0] & 8'hFC;
        v = 0;
        case (o)
            8'h00: v = m_run ? 32'd1 : 32'd0;
            8'h04: v = m_count * 32'd65536 + (m_wrap ? 32'd4 : 32'd0)
                       + (m_err ? 32'd2 : 32'd0) + (m_run ? 32'd1 : 32'd0);
            8'h08: v = m_ptr * 32'd4;
`ifdef WB_PROG_LOADER_CHECKSUM_EN
            8'h10: v = m_csum;
`endif
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [7:0] o;
        o = adr[7:0] & 8'hFC;
        x_exp_mem = 0;
        case (o)
            8'h00: begin
                if (dat[1]) begin m_count = 0; m_err = 0; m_wrap = 0; m_csum = 0; end
                m_run = dat[0];
            end
            8'h08: m_ptr = (dat / 4) % (1 << MEM_AW);
            8'h0C: begin
                if (m_run) m_err = 1;
                else begin
                    x_exp_mem  = 1;
                    x_exp_addr = MEM_AW'(m_ptr);
                    m_csum     = m_csum + dat;
                    if (m_ptr == (1 << MEM_AW) - 1) m_wrap = 1;
                    m_ptr = (m_ptr + 1) % (1 << MEM_AW);
                    if (m_count < (1 << CNT_W) - 1) m_count++;
                end
            end
            default: ;
        endcase
    endtask

    // One Wishbone transfer; memory ready held low for 'stall' write cycles.
    task automatic bus(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input int stall);
        x_done = 0; x_cycles = 0; x_we_cycles = 0; x_bad = 0;
        x_rdata = 0; x_waddr = 0; x_wdata = 0; x_core_ack = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        mem_ready_i = (stall == 0);
        while (!x_done && x_cycles < 40) begin
            @(posedge clk); #1;
            x_cycles++;
            if (wb_ack_o) begin
                x_done = 1; x_rdata = wb_dat_o; x_core_ack = core_rst_n_o;
                if (mem_we_o) x_bad = 1;
            end else if (mem_we_o) begin
                x_we_cycles++;
                if (x_we_cycles == 1) begin x_waddr = mem_addr_o; x_wdata = mem_wdata_o; end
                else if (mem_addr_o !== x_waddr || mem_wdata_o !== x_wdata) x_bad = 1;
                mem_ready_i = (x_we_cycles > stall);
            end
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; mem_ready_i = 0;
        checks++;
        if (!x_done) begin
            errors++;
            $display("FAIL timeout adr=%h: no ack after %0d cycles, required ack", adr, x_cycles);
        end
        @(posedge clk); #1;
        x_post_ack = wb_ack_o; x_post_dat = wb_dat_o;
        if (we) model_write(adr, dat);
        else begin x_exp_mem = 0; x_exp_rd = model_read(adr); end
    endtask

    task automatic test_reset();
        rst_n = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_adr_i = 0; wb_dat_i = 0; mem_ready_i = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wb_ack_o, wb_dat_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_n_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h we=%b addr=%h wdata=%h core=%b, required all 0",
                     wb_ack_o, wb_dat_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_n_o);
        end
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
        bus(0, A_STAT, 0, 0);
        checks++;
        if (x_rdata !== 32'h0 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL reset_status: got %h, required 00000000", x_rdata);
        end
        checks++;
        if (x_cycles != 1) begin
            errors++; $display("FAIL reg_latency: ack after %0d cycles, required 1", x_cycles);
        end
        checks++;
        if (core_rst_n_o !== 1'b0 || x_we_cycles != 0) begin
            errors++; $display("FAIL reset_core: core=%b we_cycles=%0d, required 0 and 0",
                               core_rst_n_o, x_we_cycles);
        end
        checks++;
        if (x_post_ack !== 1'b0 || x_post_dat !== 32'h0) begin
            errors++; $display("FAIL ack_drop: ack=%b dat=%h after ack, required 0/0",
                               x_post_ack, x_post_dat);
        end
    endtask

    task automatic test_ptr_data();
        bus(1, A_PTR, 32'h0000_0010, 0);
        bus(1, A_DATA, 32'hDEAD_BEEF, 0);
        checks++;
        if (x_we_cycles != 1 || x_waddr !== 10'd4 || x_wdata !== 32'hDEAD_BEEF || x_bad) begin
            errors++;
            $display("FAIL data_write: we_cycles=%0d addr=%0d data=%h bad=%b, required 1/4/deadbeef/0",
                     x_we_cycles, x_waddr, x_wdata, x_bad);
        end
        checks++;
        if (x_cycles != 2) begin
            errors++; $display("FAIL data_latency: ack after %0d cycles, required 2", x_cycles);
        end
        bus(0, A_PTR, 0, 0);
        checks++;
        if (x_rdata !== 32'h14 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL ptr_read: got %h, required 00000014", x_rdata);
        end
        bus(0, A_STAT, 0, 0);
        checks++;
        if (x_rdata[31:16] !== 16'd1 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL count_one: got %h, required %h", x_rdata, x_exp_rd);
        end
    endtask

    task automatic test_stall();
        bus(1, A_DATA, 32'hA5A5_0001, 5);
        checks++;
        if (x_we_cycles != 6 || x_bad || x_cycles != 7 || x_waddr !== x_exp_addr) begin
            errors++;
            $display("FAIL stall: we_cycles=%0d bad=%b ack_cycles=%0d addr=%0d, required 6/0/7/%0d",
                     x_we_cycles, x_bad, x_cycles, x_waddr, x_exp_addr);
        end
    endtask

    task automatic test_wrap();
        logic [MEM_AW-1:0] a0;
        bus(1, A_CTRL, 32'h2, 0);
        bus(1, A_PTR, 32'h0000_0FFC, 0);
        bus(1, A_DATA, 32'h1111_1111, 0);
        a0 = x_waddr;
        bus(1, A_DATA, 32'h2222_2222, 0);
        checks++;
        if (a0 !== 10'd1023 || x_waddr !== 10'd0) begin
            errors++; $display("FAIL wrap_addr: got %0d then %0d, required 1023 then 0", a0, x_waddr);
        end
        bus(0, A_STAT, 0, 0);
        checks++;
        if (x_rdata !== 32'h0002_0004 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL wrap_status: got %h, required 00020004", x_rdata);
        end
    endtask

    task automatic test_run_err();
        bus(1, A_CTRL, 32'h3, 0);
        checks++;
        if (x_core_ack !== 1'b0 || core_rst_n_o !== 1'b1) begin
            errors++; $display("FAIL core_release: at_ack=%b after=%b, required 0 then 1",
                               x_core_ack, core_rst_n_o);
        end
        bus(1, A_DATA, 32'h0000_1234, 0);
        checks++;
        if (x_we_cycles != 0 || x_cycles != 1) begin
            errors++; $display("FAIL run_write: we_cycles=%0d ack_cycles=%0d, required 0/1",
                               x_we_cycles, x_cycles);
        end
        bus(0, A_STAT, 0, 0);
        checks++;
        if (x_rdata !== 32'h0000_0003 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL run_status: got %h, required 00000003", x_rdata);
        end
        bus(1, A_CTRL, 32'h0, 0);
        checks++;
        if (x_core_ack !== 1'b1 || core_rst_n_o !== 1'b0) begin
            errors++; $display("FAIL core_reassert: at_ack=%b after=%b, required 1 then 0",
                               x_core_ack, core_rst_n_o);
        end
    endtask

    task automatic test_checksum();
        bus(1, A_CTRL, 32'h2, 0);
`ifdef WB_PROG_LOADER_CHECKSUM_EN
        bus(1, A_DATA, 32'hFFFF_FFFF, 0);
        bus(1, A_DATA, 32'h0000_0002, 0);
        bus(0, A_CSUM, 0, 0);
        checks++;
        if (x_rdata !== 32'h1 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL csum: got %h, required 00000001", x_rdata);
        end
        bus(1, A_CTRL, 32'h2, 0);
        bus(0, A_CSUM, 0, 0);
        checks++;
        if (x_rdata !== 32'h0) begin
            errors++; $display("FAIL csum_clear: got %h, required 00000000", x_rdata);
        end
`else
        bus(1, A_CSUM, 32'h5555_AAAA, 0);
        bus(0, A_CSUM, 0, 0);
        checks++;
        if (x_rdata !== 32'h0 || x_cycles != 1) begin
            errors++; $display("FAIL unmapped_0x10: got %h after %0d cycles, required 0 after 1",
                               x_rdata, x_cycles);
        end
`endif
        bus(0, A_STAT, 0, 0);
        checks++;
        if (x_rdata[31:16] !== 16'd0 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL clear_count: got %h, required %h", x_rdata, x_exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            bus(1, A_DATA, $urandom, 0);
            checks++;
            if (x_we_cycles != 1 || x_waddr !== x_exp_addr || x_cycles != 2) begin
                errors++; $display("FAIL b2b_%0d: addr=%0d we_cycles=%0d cycles=%0d, required %0d/1/2",
                                   i, x_waddr, x_we_cycles, x_cycles, x_exp_addr);
            end
        end
    endtask

    task automatic test_out_of_window();
        bit                saw;
        logic [31:0]       adrs [3];
        adrs[0] = 32'h3000_0104; adrs[1] = 32'h2000_0004; adrs[2] = 32'h4000_0008;
        saw = 0;
        for (int k = 0; k < 3; k++) begin
            wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = adrs[k]; wb_dat_i = 32'h0000_0200;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (wb_ack_o || mem_we_o) saw = 1;
            end
            wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
            @(posedge clk); #1;
        end
        checks++;
        if (saw) begin
            errors++; $display("FAIL out_of_window: ack or mem write seen, required none");
        end
        bus(0, A_PTR, 0, 0);
        checks++;
        if (x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL oow_ptr: got %h, required %h", x_rdata, x_exp_rd);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] adr, dat;
        int          st, op;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            st = $urandom_range(0, 3);
            dat = $urandom;
            case (op)
                0, 1, 2: begin we = 1; adr = A_DATA; end
                3:       begin we = 1; adr = A_PTR; end
                4:       begin we = 0; adr = A_STAT; end
                5:       begin we = 0; adr = A_PTR; end
                6:       begin we = 1; adr = A_CTRL;
                               dat = {30'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0)}; end
                7:       begin we = 0; adr = A_CTRL; end
                default: begin we = 1'($urandom_range(0, 1));
                               adr = BASE + 32'($urandom_range(0, 63) * 4); end
            endcase
            bus(we, adr, dat, st);
            checks++;
            if (!we && x_rdata !== x_exp_rd) begin
                errors++; $display("FAIL rand_read_%0d adr=%h: got %h, required %h", i, adr, x_rdata, x_exp_rd);
            end else if (x_exp_mem && (x_we_cycles != st + 1 || x_waddr !== x_exp_addr ||
                         x_wdata !== dat || x_bad || x_cycles != st + 2)) begin
                errors++;
                $display("FAIL rand_mem_%0d: we_cycles=%0d addr=%0d data=%h cycles=%0d, required %0d/%0d/%h/%0d",
                         i, x_we_cycles, x_waddr, x_wdata, x_cycles, st + 1, x_exp_addr, dat, st + 2);
            end else if (!x_exp_mem && (x_we_cycles != 0 || x_cycles != 1)) begin
                errors++; $display("FAIL rand_reg_%0d: we_cycles=%0d cycles=%0d, required 0/1",
                                   i, x_we_cycles, x_cycles);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        bus(1, A_CTRL, 32'h0, 0);
        bus(1, A_PTR, 32'h0000_0040, 0);
        seen = 0;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = A_DATA; wb_dat_i = 32'hCAFE_F00D;
        mem_ready_i = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (mem_we_o) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL mid_write_start: mem_we never rose, required 1");
        end
        rst_n = 0;
        @(posedge clk); #1;
        checks++;
        if ({wb_ack_o, wb_dat_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_n_o} !== '0) begin
            errors++; $display("FAIL mid_write_reset: ack=%b we=%b addr=%h wdata=%h, required all 0",
                               wb_ack_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
        bus(0, A_STAT, 0, 0);
        checks++;
        if (x_rdata !== 32'h0 || x_rdata !== x_exp_rd) begin
            errors++; $display("FAIL post_reset_status: got %h, required 00000000", x_rdata);
        end
        bus(0, A_PTR, 0, 0);
        checks++;
        if (x_rdata !== 32'h0) begin
            errors++; $display("FAIL post_reset_ptr: got %h, required 00000000", x_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_ptr_data();
        test_stall();
        test_wrap();
        test_run_err();
        test_checksum();
        test_back_to_back();
        test_out_of_window();
        test_random();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
